// File: rtl/vu_pkg.sv
// Shared constants and the bar-threshold helper for the VU meter.
package vu_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int LED_SEGS       = 8;
  localparam int BAR_BASE_SHIFT = 7;

  localparam logic [LED_SEGS-1:0] CLIP_PATTERN = 8'hFF;

  // Segment i lights when level >= 2^(BAR_BASE_SHIFT+i), giving a contiguous thermometer.
  function automatic logic [LED_SEGS-1:0] bar_of(input logic [SAMPLE_W-1:0] level);
    logic [LED_SEGS-1:0] seg;
    seg = '0;
    for (int i = 0; i < LED_SEGS; i++)
      seg[i] = ({16'd0, level} >= (32'd1 << (BAR_BASE_SHIFT + i)));
    return seg;
  endfunction

endpackage

// File: rtl/abs_sat16.sv
// Signed sample to unsigned magnitude, saturating full-scale negative to the 15-bit max.
module abs_sat16
  import vu_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic        [SAMPLE_W-2:0] mag
);

  logic [SAMPLE_W-2:0] neg;

  always_comb begin
    neg = ~sample[SAMPLE_W-2:0] + {{(SAMPLE_W-2){1'b0}}, 1'b1};
    if (sample[SAMPLE_W-1] && (sample[SAMPLE_W-2:0] == '0))
      mag = '1;
    else if (sample[SAMPLE_W-1])
      mag = neg;
    else
      mag = sample[SAMPLE_W-2:0];
  end

endmodule

// File: rtl/vu_meter.sv
// Stereo peak meter: decaying peak of both channels shown as an 8-LED bar,
// overridden by a full-bar flash while a recent clip is being held.
module vu_meter
  import vu_pkg::*;
#(
  parameter int                  DECAY_PERIOD = 50000,
  parameter int                  DECAY_SHIFT  = 3,
  parameter logic [SAMPLE_W-1:0] CLIP_LVL     = 16'd32000,
  parameter int                  CLIP_HOLD    = 25000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vld,
  input  logic signed [SAMPLE_W-1:0] lft_chnnl,
  input  logic signed [SAMPLE_W-1:0] rght_chnnl,
  output logic        [LED_SEGS-1:0] LED
);

  localparam int DCNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int CCNT_W = (CLIP_HOLD > 1) ? $clog2(CLIP_HOLD) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_PERIOD - 1);
  localparam logic [CCNT_W-1:0] CCNT_LOAD = CCNT_W'(CLIP_HOLD - 1);

  // Proportional decay with a floor of one count so small peaks still reach zero.
  function automatic logic [SAMPLE_W-1:0] decay_sat(input logic [SAMPLE_W-1:0] level);
    logic [SAMPLE_W-1:0] step;
    step = level >> DECAY_SHIFT;
    if (step == '0)
      step = SAMPLE_W'(1);
    return (level < step) ? '0 : (level - step);
  endfunction

  logic [SAMPLE_W-2:0] mag_l;
  logic [SAMPLE_W-2:0] mag_r;
  logic [SAMPLE_W-1:0] mag_p0;
  logic                tick_p0;
  logic                clip_load_p0;
  logic                clip_act_p0;
  logic [SAMPLE_W-1:0] peak_nxt;

  logic [DCNT_W-1:0]   decay_cnt;
  logic [CCNT_W-1:0]   clip_cnt_p1;
  logic [SAMPLE_W-1:0] peak_p1;
  logic                clip_act_p1;
  logic [LED_SEGS-1:0] seg_p1;

  abs_sat16 u_abs_l (.sample(lft_chnnl),  .mag(mag_l));
  abs_sat16 u_abs_r (.sample(rght_chnnl), .mag(mag_r));

  // Stage p0: magnitude, decay tick, clip detection, next peak
  always_comb begin
    mag_p0       = {1'b0, (mag_l > mag_r) ? mag_l : mag_r};
    tick_p0      = (decay_cnt == DCNT_LAST);
    clip_load_p0 = vld && (mag_p0 >= CLIP_LVL);
    clip_act_p0  = clip_load_p0 || (clip_cnt_p1 != '0);
    peak_nxt     = peak_p1;
    if (vld && (mag_p0 > peak_p1))
      peak_nxt = mag_p0;
    else if (tick_p0)
      peak_nxt = decay_sat(peak_p1);
  end

  // Stage p1: peak, clip hold counter and registered clip flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_cnt   <= '0;
      peak_p1     <= '0;
      clip_cnt_p1 <= '0;
      clip_act_p1 <= 1'b0;
    end else begin
      decay_cnt   <= tick_p0 ? '0 : decay_cnt + DCNT_W'(1);
      peak_p1     <= peak_nxt;
      clip_act_p1 <= clip_act_p0;
      if (clip_load_p0)
        clip_cnt_p1 <= CCNT_LOAD;
      else if (clip_cnt_p1 != '0)
        clip_cnt_p1 <= clip_cnt_p1 - CCNT_W'(1);
    end
  end

  assign seg_p1 = bar_of(peak_p1);

  // Stage p2: LED output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      LED <= '0;
    else
      LED <= clip_act_p1 ? CLIP_PATTERN : seg_p1;
  end

endmodule

// File: tb/tb_vu_meter.sv
// Directed bench for vu_meter with a short decay period and clip hold.
module tb_vu_meter;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld = 1'b0;
  logic signed [15:0] lft = '0;
  logic signed [15:0] rght = '0;
  logic [7:0]         led;

  int checks = 0;
  int errors = 0;
  int cyc;

  vu_meter #(
    .DECAY_PERIOD(8),
    .DECAY_SHIFT (3),
    .CLIP_LVL    (16'd32000),
    .CLIP_HOLD   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .lft_chnnl (lft),
    .rght_chnnl(rght),
    .LED       (led)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the DUT ticks on every edge where cyc becomes a multiple of 8.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit v, input logic signed [15:0] l, input logic signed [15:0] r);
    vld  = v;
    lft  = l;
    rght = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (((cyc % 8) != p) && (n < 16)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
    checks++;
    if (dut.peak_p1 !== 16'd0) begin errors++; $display("FAIL reset_peak: got %0d expected 0", dut.peak_p1); end
    repeat (12) @(negedge clk);
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL reset_idle_led: got %h expected 00", led); end
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 16'sd3000, -16'sd5000);
    @(negedge clk);
    drive(0, 0, 0);
    checks++;
    if (dut.peak_p1 !== 16'd5000) begin errors++; $display("FAIL single_peak: got %0d expected 5000", dut.peak_p1); end
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL single_led_n1: got %h expected 00", led); end
    @(negedge clk);
    checks++;
    if (led !== 8'h3F) begin errors++; $display("FAIL single_led_n2: got %h expected 3F", led); end
  endtask

  task automatic test_fullscale();
    int n;
    do_reset();
    drive(1, 16'sh8000, 16'sd0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      drive(0, 0, 0);
      if (k == 1) begin
        checks++;
        if (dut.peak_p1 !== 16'd32767) begin errors++; $display("FAIL fs_peak: got %0d expected 32767", dut.peak_p1); end
        checks++;
        if (led !== 8'h00) begin errors++; $display("FAIL fs_led_n1: got %h expected 00", led); end
        checks++;
        if (dut.clip_act_p1 !== 1'b1) begin errors++; $display("FAIL fs_clip_start: got %b expected 1", dut.clip_act_p1); end
      end
      if (k == 2) begin
        checks++;
        if (led !== 8'hFF) begin errors++; $display("FAIL fs_led_flash: got %h expected FF", led); end
      end
      if (k == 16) begin
        checks++;
        if (dut.clip_act_p1 !== 1'b1) begin errors++; $display("FAIL fs_clip_last: got %b expected 1", dut.clip_act_p1); end
      end
      if (k == 17) begin
        checks++;
        if (dut.clip_act_p1 !== 1'b0) begin errors++; $display("FAIL fs_clip_end: got %b expected 0", dut.clip_act_p1); end
        checks++;
        if (led !== 8'hFF) begin errors++; $display("FAIL fs_led_bar_full: got %h expected FF", led); end
      end
    end
    n = 0;
    while ((led === 8'hFF) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (led !== 8'h7F) begin errors++; $display("FAIL fs_step_down: got %h expected 7F", led); end
    checks++;
    if ((dut.peak_p1 >= 16'd16384) || (dut.peak_p1 < 16'd8192)) begin
      errors++; $display("FAIL fs_step_peak: got %0d expected in [8192,16383]", dut.peak_p1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 16'sd32000, 16'sd0);
    repeat (5) begin
      @(negedge clk);
      drive(0, 0, 0);
    end
    checks++;
    if (led !== 8'hFF) begin errors++; $display("FAIL mid_pre_led: got %h expected FF", led); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL mid_async_led: got %h expected 00", led); end
    checks++;
    if (dut.peak_p1 !== 16'd0) begin errors++; $display("FAIL mid_async_peak: got %0d expected 0", dut.peak_p1); end
    checks++;
    if (dut.clip_act_p1 !== 1'b0) begin errors++; $display("FAIL mid_async_clip: got %b expected 0", dut.clip_act_p1); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL mid_after_led: got %h expected 00", led); end
  endtask

  task automatic test_decay();
    logic [15:0] exp_seq [4];
    int n;
    exp_seq = '{16'd175, 16'd154, 16'd135, 16'd119};
    do_reset();
    drive(1, 16'sd200, 16'sd0);
    @(negedge clk);
    drive(0, 0, 0);
    checks++;
    if (dut.peak_p1 !== 16'd200) begin errors++; $display("FAIL decay_load: got %0d expected 200", dut.peak_p1); end
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (((cyc % 8) != 0) && (n < 16));
      checks++;
      if (dut.peak_p1 !== exp_seq[i]) begin
        errors++; $display("FAIL decay_step%0d: got %0d expected %0d", i, dut.peak_p1, exp_seq[i]);
      end
      if (i == 2) begin
        @(negedge clk);
        checks++;
        if (led !== 8'h01) begin errors++; $display("FAIL decay_led_135: got %h expected 01", led); end
      end
      if (i == 3) begin
        @(negedge clk);
        checks++;
        if (led !== 8'h00) begin errors++; $display("FAIL decay_led_119: got %h expected 00", led); end
      end
    end
    n = 0;
    while ((dut.peak_p1 !== 16'd0) && (n < 600)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dut.peak_p1 !== 16'd0) begin errors++; $display("FAIL decay_to_zero: got %0d expected 0", dut.peak_p1); end
    repeat (20) @(negedge clk);
    checks++;
    if (dut.peak_p1 !== 16'd0) begin errors++; $display("FAIL decay_stay_zero: got %0d expected 0", dut.peak_p1); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1, 16'sd1000, -16'sd20);
    @(negedge clk);
    drive(0, 0, 0);
    checks++;
    if (dut.peak_p1 !== 16'd1000) begin errors++; $display("FAIL sim_load: got %0d expected 1000", dut.peak_p1); end
    wait_phase(7);
    drive(1, 16'sd900, -16'sd100);
    @(negedge clk);
    drive(0, 0, 0);
    checks++;
    if (dut.peak_p1 !== 16'd875) begin errors++; $display("FAIL sim_decay_wins: got %0d expected 875", dut.peak_p1); end
    @(negedge clk);
    checks++;
    if (led !== 8'h07) begin errors++; $display("FAIL sim_led_875: got %h expected 07", led); end
    wait_phase(7);
    drive(1, -16'sd1200, 16'sd50);
    @(negedge clk);
    drive(0, 0, 0);
    checks++;
    if (dut.peak_p1 !== 16'd1200) begin errors++; $display("FAIL sim_load_wins: got %0d expected 1200", dut.peak_p1); end
    @(negedge clk);
    checks++;
    if (led !== 8'h0F) begin errors++; $display("FAIL sim_led_1200: got %h expected 0F", led); end
    drive(1, 16'sd500, 16'sd500);
    @(negedge clk);
    drive(0, 0, 0);
    checks++;
    if (dut.peak_p1 !== 16'd1200) begin errors++; $display("FAIL sim_hold: got %0d expected 1200", dut.peak_p1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 16'sd300, 16'sd0);
    @(negedge clk);
    drive(1, 16'sd0, -16'sd600);
    checks++;
    if (dut.peak_p1 !== 16'd300) begin errors++; $display("FAIL b2b_first: got %0d expected 300", dut.peak_p1); end
    @(negedge clk);
    drive(1, 16'sd400, 16'sd0);
    checks++;
    if (dut.peak_p1 !== 16'd600) begin errors++; $display("FAIL b2b_second: got %0d expected 600", dut.peak_p1); end
    @(negedge clk);
    drive(0, 0, 0);
    checks++;
    if (dut.peak_p1 !== 16'd600) begin errors++; $display("FAIL b2b_third: got %0d expected 600", dut.peak_p1); end
    checks++;
    if (led !== 8'h07) begin errors++; $display("FAIL b2b_led: got %h expected 07", led); end
  endtask

  task automatic test_clip_retrigger();
    logic exp_act;
    do_reset();
    drive(1, 16'sd0, -16'sd32000);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      exp_act = (k <= 26);
      checks++;
      if (dut.clip_act_p1 !== exp_act) begin
        errors++; $display("FAIL retrig_clip_k%0d: got %b expected %b", k, dut.clip_act_p1, exp_act);
      end
      if (k == 10)      drive(1, 16'sd32100, 16'sd0);
      else if (k == 15) drive(1, 16'sd1000, 16'sd0);
      else              drive(0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fullscale();
    test_reset_mid();
    test_decay();
    test_simultaneous();
    test_back_to_back();
    test_clip_retrigger();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
